// File: rtl/hamming_encode.sv
// ============================================================================
// Module   : hamming_encode
// Purpose  : Streaming Hamming(21,16) encoder with a small codeword FIFO and
//            a one-shot error-injection path for driving known bit faults.
// Ports    : clk            - clock
//            rstb           - asynchronous active-low reset
//            data_in        - payload word (LSB-first into data positions)
//            in_valid       - data_in valid
//            in_ready       - encoder can accept this cycle
//            inj_en         - XOR inj_mask into the word accepted this cycle
//            inj_mask       - codeword fault mask
//            encoded_data   - codeword at the FIFO head
//            out_valid      - encoded_data valid
//            out_ready      - consumer takes the head this cycle
//            word_count     - accepted-word counter, wraps modulo 2^16
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module hamming_encode #(
    parameter int DATA_WIDTH     = 16,
    parameter int ENCODING_WIDTH = 21,
    parameter int FIFO_DEPTH     = 4
) (
    input  logic                      clk,
    input  logic                      rstb,
    input  logic [DATA_WIDTH-1:0]     data_in,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic                      inj_en,
    input  logic [ENCODING_WIDTH-1:0] inj_mask,
    output logic [ENCODING_WIDTH-1:0] encoded_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [15:0]               word_count
);

    localparam int c_PAR_BITS = ENCODING_WIDTH - DATA_WIDTH;
    localparam int c_PTR_W    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int c_CNT_W    = $clog2(FIFO_DEPTH + 1);

    // Bit k of the mask is set when Hamming position k+1 has bit j set,
    // i.e. the set of positions covered by parity bit 2^j.
    function automatic logic [ENCODING_WIDTH-1:0] f_cover(input int j);
        logic [ENCODING_WIDTH-1:0] m;
        m = '0;
        for (int k = 0; k < ENCODING_WIDTH; k++) begin
            m[k] = (((k + 1) >> j) % 2) == 1;
        end
        return m;
    endfunction

    // ------------------------------------------------------------------
    // Elaboration-time parameter checks
    // ------------------------------------------------------------------
    if (DATA_WIDTH != 16) begin : g_bad_data_width
        $error("hamming_encode: only DATA_WIDTH=16 is supported");
    end
    if (ENCODING_WIDTH != DATA_WIDTH + 5) begin : g_bad_enc_width
        $error("hamming_encode: ENCODING_WIDTH must equal DATA_WIDTH+5");
    end
    if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("hamming_encode: FIFO_DEPTH must be a power of two >= 2");
    end

    // ------------------------------------------------------------------
    // Combinational encoder
    // ------------------------------------------------------------------
    logic [ENCODING_WIDTH-1:0] w_sys;   // data bits placed, parity slots zero
    logic [c_PAR_BITS-1:0]     w_par;
    logic [ENCODING_WIDTH-1:0] w_code;

    for (genvar k = 0; k < ENCODING_WIDTH; k++) begin : g_place
        // Position p holds data bit p - (number of powers of two <= p) - 1.
        localparam int c_POS = k + 1;
        if ((c_POS & (c_POS - 1)) == 0) begin : g_parity_slot
            assign w_sys[k]  = 1'b0;
            assign w_code[k] = w_par[$clog2(c_POS)];
        end else begin : g_data_slot
            localparam int c_IDX = c_POS - $clog2(c_POS + 1) - 1;
            assign w_sys[k]  = data_in[c_IDX];
            assign w_code[k] = data_in[c_IDX];
        end
    end

    for (genvar j = 0; j < c_PAR_BITS; j++) begin : g_parity
        localparam logic [ENCODING_WIDTH-1:0] c_COVER = f_cover(j);
        assign w_par[j] = ^(w_sys & c_COVER);
    end

    // ------------------------------------------------------------------
    // Codeword FIFO
    // ------------------------------------------------------------------
    logic [ENCODING_WIDTH-1:0] r_mem [FIFO_DEPTH];
    logic [c_PTR_W-1:0]        r_wr_ptr;
    logic [c_PTR_W-1:0]        r_rd_ptr;
    logic [c_CNT_W-1:0]        r_count;
    logic [15:0]               r_word_count;
    logic                      w_accept;
    logic                      w_pop;
    logic [ENCODING_WIDTH-1:0] w_wr_data;

    // Flags depend only on registered count, so out_ready never reaches in_ready.
    assign in_ready     = (r_count != c_CNT_W'(FIFO_DEPTH));
    assign out_valid    = (r_count != '0);
    assign encoded_data = r_mem[r_rd_ptr];
    assign word_count   = r_word_count;

    assign w_accept  = in_valid & in_ready;
    assign w_pop     = out_valid & out_ready;
    assign w_wr_data = w_code ^ (inj_en ? inj_mask : '0);

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_word_count <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_accept) begin
                r_mem[r_wr_ptr] <= w_wr_data;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
                r_word_count    <= r_word_count + 16'd1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_accept, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_hamming_encode.sv
// ============================================================================
// Module   : tb_hamming_encode
// Purpose  : Self-checking bench for hamming_encode: table of hand-computed
//            codewords plus directed FIFO, reset and round-trip sequences.
// Ports    : none
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_hamming_encode;

    logic        clk;
    logic        rstb;
    logic [15:0] data_in;
    logic        in_valid;
    logic        in_ready;
    logic        inj_en;
    logic [20:0] inj_mask;
    logic [20:0] encoded_data;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] word_count;

    int checks;
    int failures;

    hamming_encode u_dut (
        .clk          (clk),
        .rstb         (rstb),
        .data_in      (data_in),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .inj_en       (inj_en),
        .inj_mask     (inj_mask),
        .encoded_data (encoded_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .word_count   (word_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] data;
        logic        inj;
        logic [20:0] mask;
        logic [20:0] exp;
    } vec_t;

    vec_t vecs [9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference single-error-correcting decoder.
    function automatic logic [15:0] f_decode(input logic [20:0] cw);
        logic [4:0]  syn;
        logic [20:0] c;
        logic [15:0] d;
        int          n;
        c   = cw;
        syn = '0;
        for (int p = 1; p <= 21; p++) begin
            if (c[p-1]) syn = syn ^ 5'(p);
        end
        if (syn != 5'd0 && syn <= 5'd21) c[syn-5'd1] = ~c[syn-5'd1];
        n = 0;
        d = '0;
        for (int p = 1; p <= 21; p++) begin
            if ((p & (p - 1)) != 0) begin
                d[n] = c[p-1];
                n++;
            end
        end
        return d;
    endfunction

    logic [15:0] plain_d [6];
    logic [20:0] plain_c [6];
    logic [20:0] q [$];
    logic [15:0] wc_exp;
    logic [15:0] rd;
    logic [20:0] m;

    initial begin
        checks   = 0;
        failures = 0;

        vecs[0] = '{16'd10,    1'b0, 21'd0,        21'd82};
        vecs[1] = '{16'd19008, 1'b0, 21'd0,        21'd599040};
        vecs[2] = '{16'd19008, 1'b1, 21'd1 << 7,   21'd599168};
        vecs[3] = '{16'd19008, 1'b1, 21'd1 << 6,   21'd599104};
        vecs[4] = '{16'd19008, 1'b1, 21'd1 << 19,  21'd74752};
        vecs[5] = '{16'd0,     1'b0, 21'd0,        21'd0};
        vecs[6] = '{16'd1,     1'b0, 21'd0,        21'd7};
        vecs[7] = '{16'hFFFF,  1'b0, 21'd0,        21'd2097150};
        vecs[8] = '{16'h8000,  1'b0, 21'd0,        21'd1081353};

        plain_d = '{16'd10, 16'd19008, 16'd0, 16'd1, 16'hFFFF, 16'h8000};
        plain_c = '{21'd82, 21'd599040, 21'd0, 21'd7, 21'd2097150, 21'd1081353};

        rstb      = 1'b0;
        data_in   = '0;
        in_valid  = 1'b0;
        inj_en    = 1'b0;
        inj_mask  = '0;
        out_ready = 1'b0;

        // ---------------- reset state
        #12;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_encoded", 32'(encoded_data), 32'd0);
        check("rst_word_count", 32'(word_count), 32'd0);
        @(negedge clk);
        rstb = 1'b1;

        // ---------------- table-driven single words
        out_ready = 1'b1;
        wc_exp = 16'd0;
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            check("vec_empty_before", 32'(out_valid), 32'd0);
            data_in  = vecs[i].data;
            inj_en   = vecs[i].inj;
            inj_mask = vecs[i].mask;
            in_valid = 1'b1;
            @(negedge clk);
            in_valid = 1'b0;
            inj_en   = 1'b0;
            inj_mask = '0;
            wc_exp++;
            check("vec_out_valid", 32'(out_valid), 32'd1);
            check("vec_encoded", 32'(encoded_data), 32'(vecs[i].exp));
            check("vec_word_count", 32'(word_count), 32'(wc_exp));
        end

        // ---------------- injection ignored without accept
        @(negedge clk);
        inj_en   = 1'b1;
        inj_mask = '1;
        @(negedge clk);
        inj_en   = 1'b0;
        inj_mask = '0;
        check("inj_idle_no_word", 32'(out_valid), 32'd0);
        data_in  = 16'd10;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        wc_exp++;
        check("inj_idle_encoded", 32'(encoded_data), 32'd82);
        @(negedge clk);

        // ---------------- fill to full with consumer stalled
        out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("fill_in_ready", 32'(in_ready), (k < 4) ? 32'd1 : 32'd0);
            data_in  = (k < 4) ? plain_d[(k + 2) % 6] : 16'd10;
            in_valid = 1'b1;
        end
        @(negedge clk);
        in_valid = 1'b0;
        wc_exp += 16'd4;
        check("full_in_ready", 32'(in_ready), 32'd0);
        check("full_word_count", 32'(word_count), 32'(wc_exp));
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("stall_stable", 32'(encoded_data), 32'(plain_c[2]));
        end
        // Pop while full with a push offered: the push must be refused.
        out_ready = 1'b1;
        data_in   = 16'd10;
        in_valid  = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        check("popfull_in_ready", 32'(in_ready), 32'd1);
        check("popfull_word_count", 32'(word_count), 32'(wc_exp));
        for (int k = 1; k < 4; k++) begin
            check("drain_order", 32'(encoded_data), 32'(plain_c[(k + 2) % 6]));
            @(negedge clk);
        end
        check("drain_empty", 32'(out_valid), 32'd0);

        // ---------------- simultaneous push/pop at count=2
        q.delete();
        out_ready = 1'b0;
        @(negedge clk);
        data_in = plain_d[0]; in_valid = 1'b1; q.push_back(plain_c[0]);
        @(negedge clk);
        data_in = plain_d[1]; q.push_back(plain_c[1]);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check("pp_in_ready", 32'(in_ready), 32'd1);
            check("pp_out_valid", 32'(out_valid), 32'd1);
            check("pp_head", 32'(encoded_data), 32'(q[0]));
            void'(q.pop_front());
            data_in   = plain_d[(k + 2) % 6];
            in_valid  = 1'b1;
            out_ready = 1'b1;
            q.push_back(plain_c[(k + 2) % 6]);
        end
        @(negedge clk);
        in_valid = 1'b0;
        for (int k = 0; k < 2; k++) begin
            check("pp_drain", 32'(encoded_data), 32'(q[0]));
            void'(q.pop_front());
            @(negedge clk);
        end
        check("pp_empty", 32'(out_valid), 32'd0);

        // ---------------- reset mid-stream
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            data_in  = plain_d[k + 3];
            in_valid = 1'b1;
        end
        @(negedge clk);
        in_valid = 1'b0;
        #2 rstb = 1'b0;
        #1;
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        check("midrst_encoded", 32'(encoded_data), 32'd0);
        check("midrst_word_count", 32'(word_count), 32'd0);
        @(negedge clk);
        rstb     = 1'b1;
        data_in  = 16'd10;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        check("postrst_out_valid", 32'(out_valid), 32'd1);
        check("postrst_encoded", 32'(encoded_data), 32'd82);
        check("postrst_word_count", 32'(word_count), 32'd1);

        // ---------------- round trip through a reference decoder
        out_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            data_in  = 16'($urandom);
            m        = 21'd1 << $urandom_range(20, 0);
            inj_en   = k[0];
            inj_mask = m;
            in_valid = 1'b1;
            rd       = data_in;
            @(negedge clk);
            in_valid = 1'b0;
            inj_en   = 1'b0;
            check("roundtrip", 32'(f_decode(encoded_data)), 32'(rd));
        end

        // ---------------- word_count wrap
        @(negedge clk);
        #2 rstb = 1'b0;
        @(negedge clk);
        rstb      = 1'b1;
        out_ready = 1'b1;
        data_in   = 16'd1;
        in_valid  = 1'b1;
        repeat (65535) @(negedge clk);
        check("wc_max", 32'(word_count), 32'hFFFF);
        @(negedge clk);
        in_valid = 1'b0;
        check("wc_wrap", 32'(word_count), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
